// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: adds two WIDTH-bit operands DIGIT bits per clock
// over WIDTH/DIGIT cycles behind valid/ready handshakes on both sides.
module digit_serial_adder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                  state_q;
    // Operands and sum held as N digits so the active digit is a plain index by k_q.
    logic [N-1:0][DIGIT-1:0] a_q, b_q, sum_q;
    logic                    carry_q, c_out_q, ovf_q;
    logic [CW-1:0]           k_q;

    logic [DIGIT:0]          digit_d;
    logic                    last_d, ovf_d;

    always_comb begin
        digit_d = {1'b0, a_q[k_q]} + {1'b0, b_q[k_q]} + {{DIGIT{1'b0}}, carry_q};
        last_d  = (k_q == CW'(N - 1));
        // Only meaningful on the top digit, where digit_d[DIGIT-1] is the sum MSB.
        ovf_d   = (a_q[N-1][DIGIT-1] == b_q[N-1][DIGIT-1]) &&
                  (digit_d[DIGIT-1] != a_q[N-1][DIGIT-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= c_in ^ sub;
                        k_q     <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    sum_q[k_q] <= digit_d[DIGIT-1:0];
                    carry_q    <= digit_d[DIGIT];
                    k_q        <= k_q + CW'(1);
                    if (last_d) begin
                        c_out_q <= digit_d[DIGIT];
                        ovf_q   <= ovf_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and randomised checks of digit_serial_adder across four WIDTH/DIGIT
// configurations, each instance driven by its own in_valid/out_ready.
module tb_digit_serial_adder;

    localparam int N_RAND = 300;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a_s, b_s;
    logic        c_in_s, sub_s;
    logic [3:0]  iv, ordy;
    wire  [3:0]  ir, ov, co, of;
    wire  [63:0] s0, s1, s2;
    wire  [11:0] s3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(64), .DIGIT(4)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s), .b(b_s), .c_in(c_in_s), .sub(sub_s),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .c_out(co[0]), .overflow(of[0])
    );
    digit_serial_adder #(.WIDTH(64), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s), .b(b_s), .c_in(c_in_s), .sub(sub_s),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .c_out(co[1]), .overflow(of[1])
    );
    digit_serial_adder #(.WIDTH(64), .DIGIT(64)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_s), .b(b_s), .c_in(c_in_s), .sub(sub_s),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .c_out(co[2]), .overflow(of[2])
    );
    digit_serial_adder #(.WIDTH(12), .DIGIT(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a_s[11:0]), .b(b_s[11:0]), .c_in(c_in_s), .sub(sub_s),
        .out_valid(ov[3]), .out_ready(ordy[3]), .sum(s3), .c_out(co[3]), .overflow(of[3])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] sumof(input int i);
        case (i)
            0:       return s0;
            1:       return s1;
            2:       return s2;
            default: return {52'd0, s3};
        endcase
    endfunction

    // Behavioural reference: {c_out, sum} = a + b_eff + carry_in, reduced to w bits.
    function automatic logic [65:0] model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                          input logic ci, input logic sb);
        logic [64:0] mask, am, bm, t;
        logic [63:0] s;
        logic        c, o;
        mask = (65'd1 << w) - 65'd1;
        am   = {1'b0, av} & mask;
        bm   = {1'b0, (sb ? ~bv : bv)} & mask;
        t    = am + bm + {64'd0, ci ^ sb};
        c    = t[w];
        s    = t[63:0] & mask[63:0];
        o    = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
        return {c, o, s};
    endfunction

    // One operation on the 64/4 instance; returns results and accept-to-valid latency.
    task automatic op0(input logic [63:0] av, input logic [63:0] bv, input logic ci, input logic sb,
                       output logic [63:0] sm, output logic c, output logic o, output int lat);
        a_s = av; b_s = bv; c_in_s = ci; sub_s = sb;
        iv[0] = 1'b1; ordy[0] = 1'b0;
        tick();
        iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 100) begin
            tick();
            lat++;
        end
        sm = s0; c = co[0]; o = of[0];
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] sm;
        logic        c, o;
        int          lat, n, cyc;
        logic [65:0] exp_v [4];
        logic [3:0]  done;

        rst_n = 1'b0; iv = '0; ordy = '0;
        a_s = '0; b_s = '0; c_in_s = 1'b0; sub_s = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", ir, 4'hF);
        check("rst_out_valid", ov, 4'h0);
        check("rst_sum", s0, 64'd0);
        check("rst_flags", {co, of}, 8'h00);
        @(negedge clk) rst_n = 1'b1;

        // Carry out and latency, including in_ready dropping on the accept edge
        a_s = 64'hFFFF_FFFF_FFFF_FFFF; b_s = 64'd1; c_in_s = 1'b0; sub_s = 1'b0;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        check("accept_in_ready", ir[0], 1'b0);
        lat = 0;
        while (!ov[0] && lat < 100) begin
            tick();
            lat++;
        end
        check("carry_latency", lat, 16);
        check("carry_sum", s0, 64'd0);
        check("carry_flags", {co[0], of[0]}, 2'b10);
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;
        check("consume_out_valid", ov[0], 1'b0);
        check("consume_in_ready", ir[0], 1'b1);

        op0(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, sm, c, o, lat);
        check("ovf_sum", sm, 64'h8000_0000_0000_0000);
        check("ovf_flags", {c, o}, 2'b01);

        op0(64'd5, 64'd7, 1'b0, 1'b1, sm, c, o, lat);
        check("sub_borrow_sum", sm, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_borrow_flags", {c, o}, 2'b00);

        op0(64'd7, 64'd5, 1'b0, 1'b1, sm, c, o, lat);
        check("sub_sum", sm, 64'd2);
        check("sub_flags", {c, o}, 2'b10);

        op0(64'd7, 64'd5, 1'b1, 1'b1, sm, c, o, lat);
        check("sub_cin_sum", sm, 64'd1);
        check("sub_cin_cout", c, 1'b1);

        op0(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, sm, c, o, lat);
        check("sub_ovf_sum", sm, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sub_ovf_flags", {c, o}, 2'b11);

        // Backpressure: result held while inputs churn
        a_s = 64'd10; b_s = 64'd20; c_in_s = 1'b0; sub_s = 1'b0;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        n = 0;
        while (!ov[0] && n < 100) begin
            tick();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            iv[0] = ~iv[0];
            a_s = {$urandom, $urandom};
            b_s = {$urandom, $urandom};
            tick();
            check("bp_sum", s0, 64'd30);
            check("bp_hold", {ov[0], ir[0], co[0], of[0]}, 4'b1000);
        end
        iv[0] = 1'b0; ordy[0] = 1'b1;
        tick();
        check("bp_release", {ir[0], ov[0]}, 2'b10);

        // Back-to-back initiation interval with out_ready held high
        a_s = 64'd1; b_s = 64'd2;
        iv[0] = 1'b1;
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (!ir[0] && n < 40);
        tick();
        n++;
        iv[0] = 1'b0;
        check("ii_edges", n, 18);
        check("ii_reaccept", ir[0], 1'b0);
        n = 0;
        while (!ov[0] && n < 40) begin
            tick();
            n++;
        end
        check("ii_sum", s0, 64'd3);
        tick();
        ordy[0] = 1'b0;

        // Reset in the 5th BUSY cycle
        a_s = 64'h1111_1111_1111_1111; b_s = 64'h2222_2222_2222_2222;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        repeat (4) tick();
        check("pre_rst_partial", s0[15:0], 16'h3333);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", ov[0], 1'b0);
        check("midrst_sum", s0, 64'd0);
        check("midrst_in_ready", ir[0], 1'b1);
        @(negedge clk) rst_n = 1'b1;
        op0(64'd3, 64'd4, 1'b0, 1'b0, sm, c, o, lat);
        check("post_rst_sum", sm, 64'd7);
        check("post_rst_latency", lat, 16);

        // Random regression, all four configurations in parallel with random stalls
        for (int t = 0; t < N_RAND; t++) begin
            a_s = {$urandom, $urandom};
            b_s = {$urandom, $urandom};
            c_in_s = 1'($urandom_range(0, 1));
            sub_s  = 1'($urandom_range(0, 1));
            exp_v[0] = model(64, a_s, b_s, c_in_s, sub_s);
            exp_v[1] = exp_v[0];
            exp_v[2] = exp_v[0];
            exp_v[3] = model(12, a_s, b_s, c_in_s, sub_s);
            iv = 4'hF; ordy = '0;
            tick();
            iv = '0;
            done = '0;
            cyc = 0;
            while (!(done == 4'hF && ir == 4'hF) && cyc < 400) begin
                for (int i = 0; i < 4; i++) begin
                    if (ov[i] && !done[i]) begin
                        check($sformatf("rand_d%0d", i), {co[i], of[i], sumof(i)}, exp_v[i]);
                        done[i] = 1'b1;
                    end
                    ordy[i] = ($urandom_range(0, 3) != 0);
                end
                tick();
                cyc++;
            end
            if (cyc >= 400) check("rand_timeout", {done, ir}, 8'hFF);
        end
        ordy = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
